// File: rtl/cnn_seq.sv
// cnn_seq: inference sequencer for the CNN pipeline.
// Starts each layer in turn, watchdogs it, ships the digit over UART.
module cnn_seq #(
    parameter int NUM_LAYERS = 5,
    parameter int TIMEOUT    = 1 << 20,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  img_rdy,
    output logic                  img_ack,
    output logic [NUM_LAYERS-1:0] l_strt,
    input  logic [NUM_LAYERS-1:0] l_done,
    input  logic [3:0]            res_digit,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_TXW   = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    localparam logic [IW-1:0] LAST  = IW'(NUM_LAYERS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [CNT_W-1:0]      frame_q, frame_d;
    logic [7:0]            tx_q, tx_d;
    logic [NUM_LAYERS-1:0] strt_q, strt_d;
    logic                  err_q, err_d;
    logic                  ack_q, ack_d;
    logic                  trmt_q, trmt_d;
    logic                  busy_q, busy_d;

    // Next-state logic; every output pulse is decided on the edge that
    // enters its state, so all outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        err_d   = err_q;
        strt_d  = '0;
        ack_d   = 1'b0;
        trmt_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (img_rdy) begin
                    idx_d   = '0;
                    strt_d  = NUM_LAYERS'(1);
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (l_done[idx_q]) begin
                    if (idx_q != LAST) begin
                        idx_d   = idx_q + 1'b1;
                        strt_d  = NUM_LAYERS'(1) << idx_d;
                        state_d = S_START;
                    end else begin
                        if (res_digit <= 4'd9) begin
                            tx_d = {4'h0, res_digit};
                        end else begin
                            tx_d  = 8'hFE;
                            err_d = 1'b1;
                        end
                        trmt_d  = 1'b1;
                        state_d = S_SEND;
                    end
                end else if (tcnt_q == TLAST) begin
                    // Error byte shows first; the strobe follows a cycle later.
                    tx_d    = 8'hFF;
                    err_d   = 1'b1;
                    state_d = S_SEND;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (trmt_q) begin
                    state_d = S_TXW;
                end else begin
                    trmt_d = 1'b1;
                end
            end
            S_TXW: begin
                if (tx_done) begin
                    ack_d   = 1'b1;
                    frame_d = frame_q + 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
            frame_q <= '0;
            tx_q    <= 8'h00;
            strt_q  <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            trmt_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            strt_q  <= strt_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            trmt_q  <= trmt_d;
            busy_q  <= busy_d;
        end
    end

    assign img_ack   = ack_q;
    assign l_strt    = strt_q;
    assign trmt      = trmt_q;
    assign tx_data   = tx_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_cnn_seq.sv
// tb_cnn_seq: table-driven frames plus hand sequences for cnn_seq.
// Layer/UART responders and a tx scoreboard run in one negedge loop.
module tb_cnn_seq;

    localparam int NL = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          img_rdy;
    logic [NL-1:0] l_done;
    logic [3:0]    res_digit;
    logic          tx_done;

    logic          img_ack, trmt, busy, err;
    logic [NL-1:0] l_strt;
    logic [7:0]    tx_data;
    logic [7:0]    frame_cnt;

    logic          w_img_ack, w_trmt, w_busy, w_err;
    logic [NL-1:0] w_l_strt;
    logic [7:0]    w_tx_data;
    logic [1:0]    w_frame_cnt;

    always #5 clk = ~clk;

    cnn_seq #(.NUM_LAYERS(NL), .TIMEOUT(TO), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .img_rdy(img_rdy), .img_ack(img_ack),
        .l_strt(l_strt), .l_done(l_done), .res_digit(res_digit),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    cnn_seq #(.NUM_LAYERS(NL), .TIMEOUT(TO), .CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .img_rdy(img_rdy), .img_ack(w_img_ack),
        .l_strt(w_l_strt), .l_done(l_done), .res_digit(res_digit),
        .trmt(w_trmt), .tx_data(w_tx_data), .tx_done(tx_done),
        .busy(w_busy), .err(w_err), .frame_cnt(w_frame_cnt)
    );

    typedef struct {
        logic [3:0]             digit;
        logic [NL-1:0][5:0]     dly;
        bit                     stray;
        logic [7:0]             exp_tx;
        logic                   exp_err;
        int                     exp_nstrt;
    } vec_t;

    typedef struct {
        logic [7:0] tx;
        logic       err;
    } sb_t;

    vec_t vecs [8];
    sb_t  sbq [$];

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int n_strt = 0, n_ack = 0, n_trmt = 0;
    int exp_layer = 0;
    int last_txd = -100, last_ack = -100;
    int b2b_start = 0;
    bit b2b = 0;
    bit in_tx = 0;
    logic [7:0] tx_hold = 8'h00;

    logic [NL-1:0][5:0] cur_dly;
    bit stray, hold_tx;
    int txd_req = 0, txd_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor/scoreboard then layer and UART responders, each negedge.
    initial begin
        int cd [NL];
        int cur;
        int tx_cd;
        int r;
        sb_t e;
        for (int i = 0; i < NL; i++) cd[i] = 0;
        cur = 0;
        tx_cd = 0;
        l_done = '0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_tx = 0;
                exp_layer = 0;
            end else begin
                if (l_strt != '0) begin
                    n_strt++;
                    chk("strt_onehot", 32'($onehot(l_strt)), 32'd1);
                    chk("strt_order", 32'(l_strt), 32'(1 << exp_layer));
                    chk("strt_in_ack", 32'(img_ack), 32'd0);
                    if (l_strt[0] && b2b && last_ack > b2b_start)
                        chk("ack_to_strt", 32'(cyc - last_ack), 32'd2);
                    exp_layer++;
                end
                if (trmt) begin
                    n_trmt++;
                    if (sbq.size() == 0) begin
                        chk("sb_empty", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.tx));
                        chk("tx_err", 32'(err), 32'(e.err));
                    end
                    tx_hold = tx_data;
                    in_tx = 1;
                end else if (in_tx) begin
                    chk("tx_hold", 32'(tx_data), 32'(tx_hold));
                end
                if (img_ack) begin
                    n_ack++;
                    chk("ack_lat", 32'(cyc - last_txd), 32'd1);
                    last_ack = cyc;
                    in_tx = 0;
                    exp_layer = 0;
                end
            end
            l_done = '0;
            tx_done = 1'b0;
            for (int i = 0; i < NL; i++) begin
                if (cd[i] > 0) begin
                    cd[i]--;
                    if (cd[i] == 0) l_done[i] = 1'b1;
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (l_strt[i] && !rst) begin
                    cd[i] = int'(cur_dly[i]);
                    cur = i;
                end
            end
            if (stray && busy && cd[cur] > 0) begin
                r = int'($urandom_range(0, 3));
                if (r == 1)
                    l_done[(cur + 1 + int'($urandom_range(0, NL - 2))) % NL] = 1'b1;
                if (r == 2) tx_done = 1'b1;
            end
            if (tx_cd > 0) begin
                tx_cd--;
                if (tx_cd == 0) begin
                    tx_done = 1'b1;
                    last_txd = cyc;
                end
            end
            if (trmt && !hold_tx && !rst) tx_cd = 4;
            if (txd_req != txd_seen) begin
                tx_done = 1'b1;
                txd_seen++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_tx", 32'(tx_data), 32'd0);
        chk("rst_pulses", 32'({l_strt, trmt, img_ack}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int target, input int limit);
        int t = 0;
        while (n_ack < target && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("ack_wait", 32'(n_ack >= target), 32'd1);
    endtask

    task automatic launch();
        img_rdy = 1'b1;
        @(negedge clk);
        img_rdy = 1'b0;
        chk("strt0_lat", 32'(l_strt), 32'd1);
        chk("busy_on", 32'(busy), 32'd1);
    endtask

    initial begin
        int s0, a0, t0, t;
        rst = 1'b1;
        img_rdy = 1'b0;
        res_digit = 4'd0;
        cur_dly = '0;
        stray = 0;
        hold_tx = 0;

        vecs[0] = '{digit:4'd7,  dly:{6'd3,6'd3,6'd3,6'd3,6'd3},
                    stray:0, exp_tx:8'h07, exp_err:1'b0, exp_nstrt:5};
        vecs[1] = '{digit:4'd0,  dly:{6'd3,6'd4,6'd1,6'd5,6'd2},
                    stray:0, exp_tx:8'h00, exp_err:1'b0, exp_nstrt:5};
        vecs[2] = '{digit:4'd9,  dly:{6'd1,6'd16,6'd1,6'd16,6'd1},
                    stray:0, exp_tx:8'h09, exp_err:1'b0, exp_nstrt:5};
        vecs[3] = '{digit:4'hC,  dly:{6'd3,6'd3,6'd3,6'd3,6'd3},
                    stray:1, exp_tx:8'hFE, exp_err:1'b1, exp_nstrt:5};
        vecs[4] = '{digit:4'hF,  dly:{6'd4,6'd4,6'd4,6'd4,6'd4},
                    stray:1, exp_tx:8'hFE, exp_err:1'b1, exp_nstrt:5};
        vecs[5] = '{digit:4'd3,  dly:{6'd3,6'd3,6'd17,6'd3,6'd3},
                    stray:0, exp_tx:8'hFF, exp_err:1'b1, exp_nstrt:3};
        vecs[6] = '{digit:4'd5,  dly:{6'd3,6'd3,6'd3,6'd0,6'd3},
                    stray:0, exp_tx:8'hFF, exp_err:1'b1, exp_nstrt:2};
        vecs[7] = '{digit:4'd4,  dly:{6'd0,6'd3,6'd3,6'd3,6'd3},
                    stray:1, exp_tx:8'hFF, exp_err:1'b1, exp_nstrt:5};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            res_digit = vecs[v].digit;
            cur_dly = vecs[v].dly;
            stray = vecs[v].stray;
            sbq.push_back('{tx:vecs[v].exp_tx, err:vecs[v].exp_err});
            s0 = n_strt;
            a0 = n_ack;
            launch();
            wait_ack(a0 + 1, 300);
            repeat (2) @(negedge clk);
            chk("v_fcnt", 32'(frame_cnt), 32'd1);
            chk("v_err", 32'(err), 32'(vecs[v].exp_err));
            chk("v_nstrt", 32'(n_strt - s0), 32'(vecs[v].exp_nstrt));
            chk("v_busy", 32'(busy), 32'd0);
        end
        stray = 0;

        // Timeout on layer 2: exact error and strobe timing.
        do_reset();
        res_digit = 4'd7;
        cur_dly = {6'd3, 6'd3, 6'd0, 6'd3, 6'd3};
        sbq.push_back('{tx:8'hFF, err:1'b1});
        a0 = n_ack;
        launch();
        t = 0;
        while (!l_strt[2] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("to_strt2", 32'(l_strt[2]), 32'd1);
        repeat (TO) @(negedge clk);
        chk("to_err_early", 32'(err), 32'd0);
        @(negedge clk);
        chk("to_err", 32'(err), 32'd1);
        chk("to_tx", 32'(tx_data), 32'hFF);
        chk("to_trmt_early", 32'(trmt), 32'd0);
        @(negedge clk);
        chk("to_trmt", 32'(trmt), 32'd1);
        wait_ack(a0 + 1, 100);
        repeat (2) @(negedge clk);
        chk("to_fcnt", 32'(frame_cnt), 32'd1);

        // Back-to-back frames with img_rdy held; 2-bit counter wraps.
        do_reset();
        res_digit = 4'd6;
        cur_dly = {6'd2, 6'd2, 6'd2, 6'd2, 6'd2};
        b2b_start = cyc;
        b2b = 1;
        for (int i = 0; i < 5; i++) sbq.push_back('{tx:8'h06, err:1'b0});
        a0 = n_ack;
        img_rdy = 1'b1;
        wait_ack(a0 + 5, 600);
        img_rdy = 1'b0;
        repeat (6) @(negedge clk);
        b2b = 0;
        chk("b2b_acks", 32'(n_ack - a0), 32'd5);
        chk("b2b_fcnt", 32'(frame_cnt), 32'd5);
        chk("wrap_fcnt", 32'(w_frame_cnt), 32'd1);
        chk("wrap_idle", 32'({w_busy, w_err, w_trmt, w_img_ack}), 32'd0);
        chk("wrap_strt", 32'(w_l_strt), 32'd0);
        chk("wrap_tx", 32'(w_tx_data), 32'h06);

        // Reset while waiting for tx_done.
        res_digit = 4'hC;
        hold_tx = 1;
        sbq.push_back('{tx:8'hFE, err:1'b1});
        t0 = n_trmt;
        launch();
        t = 0;
        while (n_trmt == t0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("txw_busy", 32'(busy), 32'd1);
        chk("txw_err", 32'(err), 32'd1);
        chk("txw_fcnt", 32'(frame_cnt), 32'd5);
        a0 = n_ack;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_fcnt", 32'(frame_cnt), 32'd0);
        chk("mr_tx", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txd_req++;
        repeat (5) @(negedge clk);
        chk("mr_noack", 32'(n_ack - a0), 32'd0);
        chk("mr_idle", 32'(busy), 32'd0);
        chk("mr_fcnt2", 32'(frame_cnt), 32'd0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        hold_tx = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
